// File: rtl/mul_pipe_pkg.sv
// Shared types, opcode constants and arithmetic helpers for the multiply pipeline.
// Only a 32-bit datapath with 5-bit register addresses is supported.
package mul_pipe_pkg;

   localparam int XLEN_C = 32;
   localparam int AW_C   = 5;
   localparam int PROD_W = 66;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [AW_C-1:0]   addr;
      logic [2:0]        funct3;
      logic [XLEN_C-1:0] instruction;
      logic [XLEN_C-1:0] pc;
      logic [XLEN_C-1:0] data;
      logic [PROD_W-1:0] prod;
   } slot_t;

   localparam slot_t SLOT_RESET = '0;

   function automatic logic is_mul(input logic [XLEN_C-1:0] ins);
      return (ins[31:25] == F7_MULDIV) && (ins[6:0] == OPC_OP) && (ins[14] == 1'b0);
   endfunction

   // Operands widened to 33 bits with per-opcode signedness; the low 66 bits of
   // the sign-extended unsigned product equal the signed 66-bit product.
   function automatic logic [PROD_W-1:0] mul_product(input logic [2:0]        f3,
                                                     input logic [XLEN_C-1:0] rs1,
                                                     input logic [XLEN_C-1:0] rs2);
      logic              a_signed;
      logic              b_signed;
      logic [32:0]       a33;
      logic [32:0]       b33;
      logic [PROD_W-1:0] a66;
      logic [PROD_W-1:0] b66;
      a_signed = (f3 != F3_MULHU);
      b_signed = (f3 == F3_MUL) || (f3 == F3_MULH);
      a33      = {a_signed & rs1[31], rs1};
      b33      = {b_signed & rs2[31], rs2};
      a66      = {{33{a33[32]}}, a33};
      b66      = {{33{b33[32]}}, b33};
      return a66 * b66;
   endfunction

   function automatic logic [XLEN_C-1:0] select_result(input logic [2:0]        f3,
                                                       input logic [PROD_W-1:0] prod);
      return (f3 == F3_MUL) ? prod[31:0] : prod[63:32];
   endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Execute-side request, writeback-side result and hazard query bundle of mul_pipe.
interface mul_pipe_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            kill_i;
   logic            stall_i;
   logic [XLEN-1:0] exe_instruction_i;
   logic [XLEN-1:0] exe_pc_i;
   logic [XLEN-1:0] exe_rs1_data_i;
   logic [XLEN-1:0] exe_rs2_data_i;
   logic [AW-1:0]   exe_write_addr_i;
   logic            exe_int_write_enable_i;
   logic            wb_valid_o;
   logic [XLEN-1:0] wb_int_write_data_o;
   logic [AW-1:0]   wb_write_addr_o;
   logic            wb_int_write_enable_o;
   logic [XLEN-1:0] wb_instruction_o;
   logic [XLEN-1:0] wb_pc_o;
   logic            busy_o;
   logic [AW-1:0]   hz_addr_i;
   logic            hz_match_o;
   logic            hz_fwd_valid_o;
   logic [XLEN-1:0] hz_fwd_data_o;

   modport slave (
      input  kill_i, stall_i, exe_instruction_i, exe_pc_i, exe_rs1_data_i,
             exe_rs2_data_i, exe_write_addr_i, exe_int_write_enable_i, hz_addr_i,
      output wb_valid_o, wb_int_write_data_o, wb_write_addr_o, wb_int_write_enable_o,
             wb_instruction_o, wb_pc_o, busy_o, hz_match_o, hz_fwd_valid_o, hz_fwd_data_o
   );

   modport master (
      output kill_i, stall_i, exe_instruction_i, exe_pc_i, exe_rs1_data_i,
             exe_rs2_data_i, exe_write_addr_i, exe_int_write_enable_i, hz_addr_i,
      input  wb_valid_o, wb_int_write_data_o, wb_write_addr_o, wb_int_write_enable_o,
             wb_instruction_o, wb_pc_o, busy_o, hz_match_o, hz_fwd_valid_o, hz_fwd_data_o
   );
endinterface

// File: rtl/mul_pipe_slot.sv
// One pass-through register slot of the multiply pipeline (slots 3 and later).
module mul_pipe_slot
   import mul_pipe_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  kill_i,
   input  logic  stall_i,
   input  slot_t d_i,
   output slot_t q_o
);

   slot_t slot_q;

   // Kill clears, stall holds, otherwise take the previous slot unchanged.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot_q <= SLOT_RESET;
      end else if (kill_i) begin
         slot_q <= SLOT_RESET;
      end else if (!stall_i) begin
         slot_q <= d_i;
      end
   end

   assign q_o = slot_q;

endmodule

// File: rtl/mul_pipe.sv
// Multiplier pipeline after execute: product in slot 1, result select in slot 2,
// plain carry through slots 3..STAGES, plus a combinational hazard/forward query.
module mul_pipe
   import mul_pipe_pkg::*;
#(
   parameter int STAGES = 5,
   parameter int XLEN   = 32,
   parameter int AW     = 5
) (
   input logic       clk_i,
   input logic       rst_i,
   mul_pipe_if.slave bus
);

   slot_t slot1_d;
   slot_t slot1_q;
   slot_t slot2_d;
   slot_t slot2_q;
   slot_t slots_s [1:STAGES];

   logic [AW-1:0]   hz_addr_s;
   logic [3:0]      youngest_s;
   logic            hit_s;
   logic            match_s;
   logic            fwd_valid_s;
   logic [XLEN-1:0] fwd_data_s;
   logic            busy_s;

   // Bubbles still carry instruction and PC so writeback sees the stream intact.
   always_comb begin
      slot1_d             = SLOT_RESET;
      slot1_d.instruction = bus.exe_instruction_i;
      slot1_d.pc          = bus.exe_pc_i;
      if (is_mul(bus.exe_instruction_i)) begin
         slot1_d.valid  = 1'b1;
         slot1_d.we     = bus.exe_int_write_enable_i & (bus.exe_write_addr_i != {AW_C{1'b0}});
         slot1_d.addr   = bus.exe_write_addr_i;
         slot1_d.funct3 = bus.exe_instruction_i[14:12];
         slot1_d.prod   = mul_product(bus.exe_instruction_i[14:12],
                                      bus.exe_rs1_data_i, bus.exe_rs2_data_i);
      end else begin
         slot1_d.valid = 1'b0;
      end
   end

   // Slot 2 picks the low or high product word.
   always_comb begin
      slot2_d = slot1_q;
      if (slot1_q.valid) begin
         slot2_d.data = select_result(slot1_q.funct3, slot1_q.prod);
      end else begin
         slot2_d.data = 32'd0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot1_q <= SLOT_RESET;
         slot2_q <= SLOT_RESET;
      end else if (bus.kill_i) begin
         slot1_q <= SLOT_RESET;
         slot2_q <= SLOT_RESET;
      end else if (!bus.stall_i) begin
         slot1_q <= slot1_d;
         slot2_q <= slot2_d;
      end
   end

   assign slots_s[1] = slot1_q;
   assign slots_s[2] = slot2_q;

   for (genvar k = 3; k <= STAGES; k++) begin : gen_slot
      mul_pipe_slot u_slot (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .kill_i  (bus.kill_i),
         .stall_i (bus.stall_i),
         .d_i     (slots_s[k-1]),
         .q_o     (slots_s[k])
      );
   end

   assign hz_addr_s = bus.hz_addr_i;

   // Scan oldest to youngest so the lowest matching index wins.
   always_comb begin
      youngest_s = 4'd0;
      hit_s      = 1'b0;
      busy_s     = 1'b0;
      for (int k = STAGES; k >= 1; k--) begin
         hit_s      = slots_s[k].valid && slots_s[k].we && (slots_s[k].addr == hz_addr_s);
         youngest_s = hit_s ? 4'(k) : youngest_s;
         busy_s     = busy_s | slots_s[k].valid;
      end
      match_s     = (youngest_s != 4'd0) && (hz_addr_s != {AW_C{1'b0}});
      fwd_valid_s = match_s && (youngest_s >= 4'd2);
      if (fwd_valid_s) begin
         fwd_data_s = slots_s[youngest_s].data;
      end else begin
         fwd_data_s = 32'd0;
      end
   end

   assign bus.wb_valid_o            = slots_s[STAGES].valid;
   assign bus.wb_int_write_data_o   = slots_s[STAGES].data;
   assign bus.wb_write_addr_o       = slots_s[STAGES].addr;
   assign bus.wb_int_write_enable_o = slots_s[STAGES].we;
   assign bus.wb_instruction_o      = slots_s[STAGES].instruction;
   assign bus.wb_pc_o               = slots_s[STAGES].pc;
   assign bus.busy_o                = busy_s;
   assign bus.hz_match_o            = match_s;
   assign bus.hz_fwd_valid_o        = fwd_valid_s;
   assign bus.hz_fwd_data_o         = fwd_data_s;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: three instances (STAGES 5, 2, 8) share one stimulus.
module tb_mul_pipe;

   logic        clk;
   logic        rst;
   logic        kill;
   logic        stall;
   logic        we;
   logic [31:0] ins;
   logic [31:0] pc;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd;
   logic [4:0]  hz;

   logic [2:0]  wbv;
   logic [2:0]  wbwe;
   logic [2:0]  busy;
   logic [2:0]  hzm;
   logic [2:0]  hzfv;
   logic [31:0] wbd  [3];
   logic [31:0] wbi  [3];
   logic [31:0] wbp  [3];
   logic [31:0] hzfd [3];
   logic [4:0]  wba  [3];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int ST = (g == 0) ? 5 : ((g == 1) ? 2 : 8);
      mul_pipe_if u_if ();
      assign u_if.kill_i                 = kill;
      assign u_if.stall_i                = stall;
      assign u_if.exe_instruction_i      = ins;
      assign u_if.exe_pc_i               = pc;
      assign u_if.exe_rs1_data_i         = a;
      assign u_if.exe_rs2_data_i         = b;
      assign u_if.exe_write_addr_i       = rd;
      assign u_if.exe_int_write_enable_i = we;
      assign u_if.hz_addr_i              = hz;
      mul_pipe #(.STAGES(ST), .XLEN(32), .AW(5)) u_dut (
         .clk_i (clk),
         .rst_i (rst),
         .bus   (u_if)
      );
      assign wbv[g]  = u_if.wb_valid_o;
      assign wbwe[g] = u_if.wb_int_write_enable_o;
      assign busy[g] = u_if.busy_o;
      assign hzm[g]  = u_if.hz_match_o;
      assign hzfv[g] = u_if.hz_fwd_valid_o;
      assign wbd[g]  = u_if.wb_int_write_data_o;
      assign wbi[g]  = u_if.wb_instruction_o;
      assign wbp[g]  = u_if.wb_pc_o;
      assign hzfd[g] = u_if.hz_fwd_data_o;
      assign wba[g]  = u_if.wb_write_addr_o;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc, input logic [4:0] r);
      return {f7, 5'd2, 5'd1, f3, r, opc};
   endfunction

   function automatic int lat(input int d);
      case (d)
         0:       return 5;
         1:       return 2;
         default: return 8;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed 0x%08h expected 0x%08h", tag, d, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r, input logic w);
      ins = i; pc = p; a = x; b = y; rd = r; we = w;
   endtask

   task automatic check_zero(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk({tag, "_busy"},  d, 32'(busy[d]), 32'd0);
         chk({tag, "_valid"}, d, 32'(wbv[d]),  32'd0);
         chk({tag, "_we"},    d, 32'(wbwe[d]), 32'd0);
         chk({tag, "_addr"},  d, 32'(wba[d]),  32'd0);
         chk({tag, "_data"},  d, wbd[d],       32'd0);
         chk({tag, "_instr"}, d, wbi[d],       32'd0);
         chk({tag, "_pc"},    d, wbp[d],       32'd0);
      end
   endtask

   // One instruction followed by bubbles; each instance checked at its own latency.
   task automatic run_vec(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] x, input logic [31:0] y, input logic [4:0] r,
                          input logic w, input logic [31:0] p, input logic ev,
                          input logic ewe, input logic [4:0] ea, input logic [31:0] ed);
      logic [31:0] i;
      i = mk(f7, f3, 7'b0110011, r);
      drive(i, p, x, y, r, w);
      tick();
      drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      for (int t = 2; t <= 8; t++) begin
         tick();
         for (int d = 0; d < 3; d++) begin
            if (t == lat(d)) begin
               chk({tag, "_valid"}, d, 32'(wbv[d]),  32'(ev));
               chk({tag, "_we"},    d, 32'(wbwe[d]), 32'(ewe));
               chk({tag, "_addr"},  d, 32'(wba[d]),  32'(ea));
               chk({tag, "_data"},  d, wbd[d],       ed);
               chk({tag, "_instr"}, d, wbi[d],       i);
               chk({tag, "_pc"},    d, wbp[d],       p);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; kill = 1'b0; stall = 1'b0; hz = 5'd0;
      drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_zero("reset");

      run_vec("mul",     7'b0000001, 3'b000, 32'd7,        32'd6,        5'd3,  1'b1, 32'h100, 1'b1, 1'b1, 5'd3,  32'd42);
      run_vec("mulh",    7'b0000001, 3'b001, 32'h80000000, 32'h80000000, 5'd5,  1'b1, 32'h104, 1'b1, 1'b1, 5'd5,  32'h40000000);
      run_vec("mulhsu",  7'b0000001, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  1'b1, 32'h108, 1'b1, 1'b1, 5'd6,  32'hFFFFFFFF);
      run_vec("mulhu",   7'b0000001, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b1, 32'h10C, 1'b1, 1'b1, 5'd7,  32'hFFFFFFFE);
      run_vec("mul_neg", 7'b0000001, 3'b000, 32'hFFFFFFFD, 32'd5,        5'd8,  1'b1, 32'h110, 1'b1, 1'b1, 5'd8,  32'hFFFFFFF1);
      run_vec("mulh_n",  7'b0000001, 3'b001, 32'hFFFFFFFD, 32'd5,        5'd10, 1'b1, 32'h114, 1'b1, 1'b1, 5'd10, 32'hFFFFFFFF);
      run_vec("mulhu_n", 7'b0000001, 3'b011, 32'hFFFFFFFD, 32'd5,        5'd11, 1'b1, 32'h118, 1'b1, 1'b1, 5'd11, 32'd4);
      run_vec("mulhsu2", 7'b0000001, 3'b010, 32'd2,        32'h80000000, 5'd12, 1'b1, 32'h11C, 1'b1, 1'b1, 5'd12, 32'd1);
      run_vec("add",     7'b0000000, 3'b000, 32'd7,        32'd6,        5'd13, 1'b1, 32'h120, 1'b0, 1'b0, 5'd0,  32'd0);
      run_vec("mul_x0",  7'b0000001, 3'b000, 32'd3,        32'd5,        5'd0,  1'b1, 32'h124, 1'b1, 1'b0, 5'd0,  32'd15);
      run_vec("mul_nwe", 7'b0000001, 3'b000, 32'd3,        32'd5,        5'd4,  1'b0, 32'h128, 1'b1, 1'b0, 5'd4,  32'd15);
      run_vec("div",     7'b0000001, 3'b100, 32'd9,        32'd3,        5'd14, 1'b1, 32'h12C, 1'b0, 1'b0, 5'd0,  32'd0);

      // Back-to-back A=6, B=20, C=42 with stall on ticks 4 and 5.
      for (int t = 1; t <= 12; t++) begin
         case (t)
            1:       drive(mk(7'b0000001, 3'b000, 7'b0110011, 5'd1), 32'h200, 32'd2, 32'd3, 5'd1, 1'b1);
            2:       drive(mk(7'b0000001, 3'b000, 7'b0110011, 5'd2), 32'h204, 32'd4, 32'd5, 5'd2, 1'b1);
            3:       drive(mk(7'b0000001, 3'b000, 7'b0110011, 5'd3), 32'h208, 32'd6, 32'd7, 5'd3, 1'b1);
            default: drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
         endcase
         stall = (t == 4) || (t == 5);
         tick();
         case (t)
            2:  chk("b2b_A", 1, wbd[1], 32'd6);
            3:  chk("b2b_B", 1, wbd[1], 32'd20);
            4:  chk("b2b_hold", 1, wbd[1], 32'd20);
            6:  begin
                   chk("b2b_C", 1, wbd[1], 32'd42);
                   chk("b2b_stall_valid", 0, 32'(wbv[0]), 32'd0);
                end
            7:  chk("b2b_A", 0, wbd[0], 32'd6);
            8:  chk("b2b_B", 0, wbd[0], 32'd20);
            9:  begin
                   chk("b2b_C", 0, wbd[0], 32'd42);
                   chk("b2b_C_addr", 0, 32'(wba[0]), 32'd3);
                end
            10: chk("b2b_A", 2, wbd[2], 32'd6);
            11: chk("b2b_B", 2, wbd[2], 32'd20);
            12: chk("b2b_C", 2, wbd[2], 32'd42);
            default: ;
         endcase
      end
      stall = 1'b0;

      // Fill every instance, then kill with stall and a new multiply present.
      drive(mk(7'b0000001, 3'b000, 7'b0110011, 5'd7), 32'h300, 32'd3, 32'd3, 5'd7, 1'b1);
      for (int t = 0; t < 8; t++) tick();
      for (int d = 0; d < 3; d++) begin
         chk("full_valid", d, 32'(wbv[d]), 32'd1);
         chk("full_busy",  d, 32'(busy[d]), 32'd1);
      end
      kill = 1'b1;
      stall = 1'b1;
      tick();
      check_zero("kill");
      kill = 1'b0;
      stall = 1'b0;

      // Hazard query: two multiplies to x9, youngest one wins.
      drive(mk(7'b0000001, 3'b000, 7'b0110011, 5'd9), 32'h400, 32'd11, 32'd13, 5'd9, 1'b1);
      tick();
      drive(mk(7'b0000001, 3'b000, 7'b0110011, 5'd9), 32'h404, 32'd2, 32'd2, 5'd9, 1'b1);
      hz = 5'd9;
      #1;
      chk("hz_s1_match", 0, 32'(hzm[0]),  32'd1);
      chk("hz_s1_fwdv",  0, 32'(hzfv[0]), 32'd0);
      chk("hz_s1_fwdd",  0, hzfd[0],      32'd0);
      hz = 5'd0;
      #1;
      chk("hz_x0_match", 0, 32'(hzm[0]), 32'd0);
      hz = 5'd3;
      #1;
      chk("hz_miss_match", 0, 32'(hzm[0]), 32'd0);
      hz = 5'd9;
      tick();
      chk("hz_two_match", 0, 32'(hzm[0]),  32'd1);
      chk("hz_two_fwdv",  0, 32'(hzfv[0]), 32'd0);
      chk("hz_two_fwdd",  0, hzfd[0],      32'd0);
      drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("hz_s2_match", d, 32'(hzm[d]),  32'd1);
         chk("hz_s2_fwdv",  d, 32'(hzfv[d]), 32'd1);
         chk("hz_s2_fwdd",  d, hzfd[d],      32'd4);
      end
      hz = 5'd0;

      // Asynchronous reset with every instance full.
      drive(mk(7'b0000001, 3'b001, 7'b0110011, 5'd6), 32'h500, 32'h80000000, 32'h80000000, 5'd6, 1'b1);
      for (int t = 0; t < 8; t++) tick();
      for (int d = 0; d < 3; d++) begin
         chk("pre_rst_valid", d, 32'(wbv[d]), 32'd1);
         chk("pre_rst_data",  d, wbd[d],      32'h40000000);
      end
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      tick();
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised multiplier pipeline placed after the execute stage; successor to the fixed single exe→mult1 latch. Accepts RV32M multiply instructions (MUL, MULH, MULHSU, MULHU) from execute, computes the product and carries it, with destination, write-enable, instruction and PC, through STAGES register slots to a writeback-facing output. Supports global stall, flush, x0 suppression and a combinational hazard/forwarding query port for the issue logic.

## Interface
- STAGES, 5, number of register slots (legal 2..8); result appears at output STAGES edges after capture
- XLEN, 32, data/instruction/PC width (only 32 supported)
- AW, 5, register address width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- kill_i  in  1  synchronous flush of every slot
- stall_i  in  1  hold every slot
- exe_instruction_i  in  XLEN  instruction in execute
- exe_pc_i  in  XLEN  PC of that instruction
- exe_rs1_data_i / exe_rs2_data_i  in  XLEN  operands
- exe_write_addr_i  in  AW  destination register
- exe_int_write_enable_i  in  1  execute-stage write enable
- wb_valid_o  out  1  final slot holds a multiply
- wb_int_write_data_o  out  XLEN  result
- wb_write_addr_o  out  AW  destination
- wb_int_write_enable_o  out  1  write enable to register file
- wb_instruction_o / wb_pc_o  out  XLEN  carried instruction / PC
- busy_o  out  1  any slot valid
- hz_addr_i  in  AW  register queried by issue logic
- hz_match_o  out  1  some valid, enabled slot targets hz_addr_i
- hz_fwd_valid_o  out  1  youngest matching slot already has its result
- hz_fwd_data_o  out  XLEN  result from that slot

## Operation
- Multiply class: instruction[31:25]=7'b0000001, [6:0]=7'b0110011, [14]=0. Anything else is a bubble.
- Slot 1 capture (not stalled): multiply → valid=1, we=exe_int_write_enable_i & (exe_write_addr_i≠0), addr, instruction, PC, funct3, raw 66-bit product. Bubble → valid=0, we=0, addr=0, data=0; instruction and PC still captured.
- Product: rs1, rs2 extended to 33 bits; rs1 signed for MUL/MULH/MULHSU, rs2 signed for MUL/MULH only; signed 66-bit multiply.
- Slot 2: data = product[31:0] for MUL (funct3=000), product[63:32] otherwise. Slots 3..STAGES copy the previous slot unchanged.
- Output ports are the fields of slot STAGES, registered.
- stall_i=1: every slot holds, no capture.
- kill_i=1 (priority over stall_i): every slot cleared to reset values at the edge.
- hz_match_o: OR over slots of valid & we & addr==hz_addr_i; forced 0 when hz_addr_i=0.
- Youngest matching slot = lowest index. hz_fwd_valid_o=1 iff that index ≥2; hz_fwd_data_o = its data, else 0.
- busy_o = OR of slot valids.

## Timing
- Reset (async assert, synchronous release): every slot field 0; all outputs 0.
- Latency: instruction present before edge n appears on wb_* after edge n+STAGES−1, absent stalls; each stall cycle adds one.
- Throughput one per cycle; back-to-back multiplies never collide.
- Hazard outputs combinational from slot state and hz_addr_i; no dependency on exe_* inputs.
- rst_i asserted mid-stream discards all in-flight work within the same cycle.
- kill_i and a new multiply in the same cycle: the new multiply is not captured.

## Structure
- Package mul_pipe_pkg: OPC_OP, F7_MULDIV, funct3 constants (F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU), slot record struct (valid, we, addr, funct3, instruction, pc, data, prod).
- Sub-module mul_pipe_slot: one register slot with stall hold, kill/reset clear; instantiated STAGES−2 times via generate for slots 3..STAGES. Slots 1 and 2 stay in the top level.

## Test plan
- MUL rs1=7, rs2=6, addr=3, STAGES=5 → after 5 edges wb_valid_o=1, data=42, we=1, addr=3, PC/instruction intact.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU same operands → 0xFFFFFFFE.
- ADD instruction (funct7=0) → wb_valid_o=0, we=0, data=0, instruction/PC forwarded; MUL to x0 → valid=1, we=0.
- Three back-to-back MULs, stall_i high two cycles mid-stream → outputs in order, latency +2; kill_i with stall_i → all slots cleared, busy_o=0.
- MUL to x9 in slot 1: hz_addr_i=9 → match=1, fwd_valid=0; one edge later → fwd_valid=1, fwd_data=product; hz_addr_i=0 → match=0.
- rst_i pulsed asynchronously with pipe full → all outputs 0 immediately; repeat full suite with STAGES=2 and 8.
